spi2adc_rx: RTL and testbench

- SPI master that reads one 10-bit conversion from the board's MCP3002-style 2-channel ADC per start request.
- It is the read-direction counterpart of the DAC write path.
- A tick from the clock-tick divider supplies start. The result feeds the pwm/spi2dac datapath in place of the switches.
- Mode 0,0: SCK idles low, MOSI changes on the falling edge, MISO is sampled on the rising edge.

---
 rtl/spi_adc_pkg.sv | 33 +++
 rtl/spi_sck_gen.sv | 60 ++++++
 rtl/spi2adc_rx.sv | 136 +++++++++++++
 tb/tb_spi2adc_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Frame layout, index types and FSM states for the MCP3002-style ADC read path.
package spi_adc_pkg;

    localparam int FRAME_LEN = 16;
    localparam int ADC_BITS  = 10;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t CMD_BITS     = idx_t'(4);
    localparam idx_t CH_IDX       = idx_t'(2);
    localparam idx_t NULL_IDX     = idx_t'(4);
    localparam idx_t DATA_MSB_IDX = NULL_IDX + idx_t'(1);
    localparam idx_t DATA_LSB_IDX = idx_t'(14);
    localparam idx_t LAST_IDX     = idx_t'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, RECOVER} state_t;

    // Command word sent MSB-first: start, single-ended, channel, MSB-first.
    function automatic logic mosi_bit(input idx_t k, input logic ch);
        logic b;
        b = 1'b0;
        if (k < CMD_BITS) begin
            b = (k == CH_IDX) ? ch : 1'b1;
        end
        return b;
    endfunction

    function automatic logic is_data_idx(input idx_t k);
        return (k >= DATA_MSB_IDX) && (k <= DATA_LSB_IDX);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: CLK_DIV-cycle half periods while enabled, idle low otherwise.
module spi_sck_gen
    import spi_adc_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise_pulse,
    output logic fall_pulse,
    output idx_t edge_idx
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    idx_t       idx_q, idx_d;
    logic       half_done;

    // Pulses mark the clock edge at which SCK toggles, so users act in lock-step with it.
    assign half_done  = en && (cnt_q == DIV_LAST);
    assign rise_pulse = half_done && !sck_q;
    assign fall_pulse = half_done && sck_q;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        sck_d = sck_q;
        idx_d = idx_q;
        if (!en) begin
            cnt_d = '0;
            sck_d = 1'b0;
            idx_d = '0;
        end else if (half_done) begin
            cnt_d = '0;
            sck_d = !sck_q;
            if (sck_q) begin
                idx_d = idx_q + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
            idx_q <= idx_d;
        end
    end

    assign sck      = sck_q;
    assign edge_idx = idx_q;

endmodule

// File: rtl/spi2adc_rx.sv
// SPI master reading one 10-bit conversion from a 2-channel ADC per accepted start.
module spi2adc_rx
    import spi_adc_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                start,
    input  logic                channel,
    input  logic                ADC_SDO,
    output logic                ADC_CS,
    output logic                ADC_SDI,
    output logic                ADC_SCK,
    output logic [ADC_BITS-1:0] data_out,
    output logic                data_valid,
    output logic                busy
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                cs_q, cs_d;
    logic                sdi_q, sdi_d;
    logic                ch_q, ch_d;
    logic [ADC_BITS-1:0] sr_q, sr_d;
    logic [ADC_BITS-1:0] dout_q, dout_d;
    logic                dv_q, dv_d;
    logic [7:0]          rec_q, rec_d;

    logic sck_en, rise_pulse, fall_pulse;
    idx_t edge_idx;

    assign sck_en = (state_q == SETUP) || (state_q == SHIFT);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk        (CLOCK_50),
        .rst_n      (RESET_N),
        .en         (sck_en),
        .sck        (ADC_SCK),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .edge_idx   (edge_idx)
    );

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cs_d    = cs_q;
        sdi_d   = sdi_q;
        ch_d    = ch_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        rec_d   = rec_q;

        if (rise_pulse && is_data_idx(edge_idx)) begin
            sr_d = {sr_q[ADC_BITS-2:0], ADC_SDO};
        end

        case (state_q)
            IDLE: begin
                if (start && !busy_q) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    sdi_d   = mosi_bit(idx_t'(0), channel);
                    ch_d    = channel;
                    sr_d    = '0;
                end
            end
            SETUP: begin
                if (rise_pulse) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_pulse) begin
                    if (edge_idx == LAST_IDX) begin
                        state_d = RECOVER;
                        cs_d    = 1'b1;
                        sdi_d   = 1'b0;
                        dout_d  = sr_q;
                        dv_d    = 1'b1;
                        rec_d   = '0;
                    end else begin
                        sdi_d = mosi_bit(edge_idx + idx_t'(1), ch_q);
                    end
                end
            end
            RECOVER: begin
                // CS held high for one half period before another start can be taken.
                if (rec_q == DIV_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    rec_d   = '0;
                end else begin
                    rec_d = rec_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            sdi_q   <= 1'b0;
            ch_q    <= 1'b0;
            sr_q    <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cs_q    <= cs_d;
            sdi_q   <= sdi_d;
            ch_q    <= ch_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            rec_q   <= rec_d;
        end
    end

    assign ADC_CS     = cs_q;
    assign ADC_SDI    = sdi_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_spi2adc_rx.sv
// Two ADC readers (CLK_DIV 25 and 2) driven by a behavioural ADC model; frame timing from closed-form rules.
module tb_spi2adc_rx;

    localparam int DIV0 = 25;
    localparam int DIV1 = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n   [2];
    logic       start_s [2];
    logic       ch_s    [2];
    logic       sdo_r   [2] = '{1'b0, 1'b0};
    logic       cs      [2];
    logic       sdi     [2];
    logic       sck     [2];
    logic       dv      [2];
    logic       busy    [2];
    logic [9:0] dout    [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            spi2adc_rx #(.CLK_DIV(gi == 0 ? DIV0 : DIV1)) u_dut (
                .CLOCK_50   (clk),
                .RESET_N    (rst_n[gi]),
                .start      (start_s[gi]),
                .channel    (ch_s[gi]),
                .ADC_SDO    (sdo_r[gi]),
                .ADC_CS     (cs[gi]),
                .ADC_SDI    (sdi[gi]),
                .ADC_SCK    (sck[gi]),
                .data_out   (dout[gi]),
                .data_valid (dv[gi]),
                .busy       (busy[gi])
            );
        end
    endgenerate

    // ADC model inputs: conversion word plus the values driven on the discarded slots.
    logic [9:0] word_m [2];
    logic       null_m [2];
    logic       tail_m [2];

    function automatic logic fbit(input int u, input int k);
        logic b;
        b = 1'b0;
        if (k == 4)                b = null_m[u];
        else if (k >= 5 && k <= 14) b = word_m[u][14 - k];
        else if (k == 15)          b = tail_m[u];
        return b;
    endfunction

    // Monitor / ADC model state (written only here).
    logic        cs_prev   [2] = '{1'b1, 1'b1};
    logic        sck_prev  [2] = '{1'b0, 1'b0};
    int          k_r       [2] = '{0, 0};
    int          ridx      [2] = '{0, 0};
    logic [15:0] mosi_cap  [2] = '{16'h0, 16'h0};
    int          rise_n    [2] = '{0, 0};
    int          cs_fall_n [2] = '{0, 0};
    int          dv_n      [2] = '{0, 0};
    int          dv_cyc    [2] = '{0, 0};
    logic [9:0]  dv_dat    [2] = '{10'h0, 10'h0};

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            cs_prev[u]  <= cs[u];
            sck_prev[u] <= sck[u];
            if (dv[u]) begin
                dv_n[u]   <= dv_n[u] + 1;
                dv_cyc[u] <= cyc;
                dv_dat[u] <= dout[u];
            end
            if (cs_prev[u] && !cs[u]) begin
                cs_fall_n[u] <= cs_fall_n[u] + 1;
                k_r[u]       <= 0;
                sdo_r[u]     <= fbit(u, 0);
                ridx[u]      <= 0;
                mosi_cap[u]  <= '0;
            end else if (!cs[u] && sck_prev[u] && !sck[u]) begin
                k_r[u]   <= k_r[u] + 1;
                sdo_r[u] <= fbit(u, k_r[u] + 1);
            end
            if (!sck_prev[u] && sck[u]) begin
                rise_n[u] <= rise_n[u] + 1;
                if (!cs[u] && ridx[u] < 16) begin
                    mosi_cap[u][ridx[u]] <= sdi[u];
                    ridx[u]              <= ridx[u] + 1;
                end
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic run_frame(input int u, input logic ch, input logic [9:0] word,
                             input logic nb, input logic tb, input bit extra);
        int div, t0, n, dv0, cs0, r0, bound;
        div = (u == 0) ? DIV0 : DIV1;
        word_m[u] = word;
        null_m[u] = nb;
        tail_m[u] = tb;
        dv0 = dv_n[u];
        cs0 = cs_fall_n[u];
        r0  = rise_n[u];
        t0  = cyc;
        start_s[u] = 1'b1;
        ch_s[u]    = ch;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        ch_s[u]    = 1'($urandom_range(0, 1));
        chk("cs_fall_t0p1", {29'h0, cs[u], busy[u], sdi[u]}, 32'b011);
        n = 0;
        bound = 33 * div + 50;
        while (busy[u] === 1'b1 && n < bound) begin
            @(posedge clk); #1;
            n++;
            ch_s[u] = 1'($urandom_range(0, 1));
            if (extra) start_s[u] = (cyc == t0 + 5) || (cyc == t0 + 400);
        end
        start_s[u] = 1'b0;
        chk("busy_fall_cycle", cyc, t0 + 1 + 33 * div);
        chk("dv_count", dv_n[u] - dv0, 1);
        chk("dv_cycle", dv_cyc[u], t0 + 1 + 32 * div);
        chk("dv_data", dv_dat[u], word);
        chk("data_out_held", dout[u], word);
        chk("sck_rises", rise_n[u] - r0, 16);
        chk("cs_falls", cs_fall_n[u] - cs0, 1);
        chk("mosi_bits", mosi_cap[u], {12'h0, 1'b1, ch, 1'b1, 1'b1});
        $display("frame u=%0d div=%0d ch=%0d word=%03h null=%0d tail=%0d got=%03h extra_starts=%0d",
                 u, div, ch, word, nb, tb, dv_dat[u], extra);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, dv0;
        logic [9:0] last0, w;
        logic bad;
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; start_s[u] = 1'b0; ch_s[u] = 1'b0;
            word_m[u] = '0; null_m[u] = 1'b0; tail_m[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("reset_state", {cs[u], sck[u], sdi[u], busy[u], dv[u], dout[u]}, {5'b10000, 10'h000});
            $display("reset check u=%0d cs=%0d sck=%0d busy=%0d dout=%03h", u, cs[u], sck[u], busy[u], dout[u]);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk); #1;

        // Channel 0 read at the 1 MHz rate.
        run_frame(0, 1'b0, 10'h2A5, 1'b0, 1'b0, 1'b0);
        // Starts during a frame are dropped.
        w = 10'($urandom);
        run_frame(0, 1'b1, w, 1'b0, 1'b0, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        chk("no_queued_start", {31'h0, busy[0]}, 0);

        // Fast divider: back-to-back frames, discard positions, random words.
        run_frame(1, 1'b1, 10'h001, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_frame(1, 1'($urandom_range(0, 1)), 10'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a frame.
        dv0 = dv_n[0];
        word_m[0] = 10'h155;
        t0 = cyc;
        start_s[0] = 1'b1; ch_s[0] = 1'b0;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        while (cyc < t0 + 300) begin @(posedge clk); #1; end
        rst_n[0] = 1'b0;
        #1;
        chk("midframe_reset", {cs[0], sck[0], sdi[0], busy[0], dv[0], dout[0]}, {5'b10000, 10'h000});
        repeat (3) begin @(posedge clk); #1; end
        rst_n[0] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("reset_no_dv", dv_n[0] - dv0, 0);
        chk("reset_dout_zero", dout[0], 10'h000);
        $display("midframe reset u=0 at cyc=%0d cs=%0d busy=%0d", t0 + 300, cs[0], busy[0]);
        last0 = 10'($urandom);
        run_frame(0, 1'($urandom_range(0, 1)), last0, 1'b0, 1'b1, 1'b0);

        // Idle: nothing moves and the last result is held.
        dv0 = dv_n[0];
        t0  = rise_n[0];
        bad = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (sck[0] !== 1'b0 || cs[0] !== 1'b1 || dv[0] !== 1'b0 || dout[0] !== last0) bad = 1'b1;
        end
        chk("idle_quiet", {31'h0, bad}, 0);
        chk("idle_no_dv", dv_n[0] - dv0, 0);
        chk("idle_no_sck", rise_n[0] - t0, 0);
        $display("idle u=0 1000 cycles dout=%03h", dout[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
